// File: rtl/key_debounce_multi.sv
// rtl/key_debounce_multi.sv - multi-channel key synchroniser, debouncer and press/release/long/toggle conditioner
// Each channel is an independent sync -> debounce -> hold-timer pipeline; no state is shared.
module key_debounce_multi #(
    parameter int N_KEYS      = 4,
    parameter int DB_CYCLES   = 1_000_000,
    parameter int LONG_CYCLES = 50_000_000,
    parameter bit ACTIVE_LOW  = 1'b1,
    parameter bit TOGGLE_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] long_pulse,
    output logic [N_KEYS-1:0] toggle
);

    localparam int DBW = $clog2(DB_CYCLES);
    localparam int HW  = $clog2(LONG_CYCLES + 1);

    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
    localparam logic [HW-1:0]  HOLD_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic           IDLE_PIN  = ACTIVE_LOW;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        logic           sync1;
        logic           sync2;
        logic           raw_p;
        logic           level;
        logic           press;
        logic           rel;
        logic           long_p;
        logic           tog;
        logic [DBW-1:0] db_cnt;
        logic [HW-1:0]  hold_cnt;

        assign raw_p = sync2 ^ ACTIVE_LOW;

        always_ff @(posedge clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                sync1 <= IDLE_PIN;
                sync2 <= IDLE_PIN;
            end else begin
                sync1 <= key_in[i];
                sync2 <= sync1;
            end
        end

        // Any sample agreeing with the current level restarts the stability count.
        always_ff @(posedge clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                level  <= 1'b0;
                db_cnt <= '0;
                press  <= 1'b0;
                rel    <= 1'b0;
            end else begin
                press <= 1'b0;
                rel   <= 1'b0;
                if (raw_p == level) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_LAST) begin
                    level  <= raw_p;
                    db_cnt <= '0;
                    press  <= raw_p;
                    rel    <= ~raw_p;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end

        // Saturating hold count makes long_p fire once per press, never repeating.
        always_ff @(posedge clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                hold_cnt <= '0;
                long_p   <= 1'b0;
            end else begin
                if (!level) begin
                    hold_cnt <= '0;
                end else if (hold_cnt < HOLD_MAX) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
                long_p <= level && (hold_cnt == HOLD_LAST);
            end
        end

        always_ff @(posedge clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                tog <= TOGGLE_INIT;
            end else if (press) begin
                tog <= ~tog;
            end
        end

        assign key_level[i]     = level;
        assign press_pulse[i]   = press;
        assign release_pulse[i] = rel;
        assign long_pulse[i]    = long_p;
        assign toggle[i]        = tog;
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// tb/tb_key_debounce_multi.sv - self-checking bench for key_debounce_multi against a behavioural model
module tb_key_debounce_multi;

    localparam int N   = 2;
    localparam int DB  = 8;
    localparam int LNG = 32;

    logic         clk = 1'b0;
    logic         sys_rst_n = 1'b0;
    logic [N-1:0] key_in = 2'b11;
    logic [N-1:0] key_level;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;
    logic [N-1:0] long_pulse;
    logic [N-1:0] toggle;

    int n_chk  = 0;
    int n_fail = 0;
    int press_cnt0 = 0;
    int long_cnt1  = 0;

    key_debounce_multi #(
        .N_KEYS(N), .DB_CYCLES(DB), .LONG_CYCLES(LNG), .ACTIVE_LOW(1'b1), .TOGGLE_INIT(1'b0)
    ) dut (
        .clk(clk), .sys_rst_n(sys_rst_n), .key_in(key_in), .key_level(key_level),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_pulse(long_pulse), .toggle(toggle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: pin seen two edges late; level flips after DB consecutive disagreeing samples;
    // long fires when the level has been high for exactly LNG edges.
    bit m_p1 [N] = '{default: 1'b0};
    bit m_p2 [N] = '{default: 1'b0};
    int m_run [N] = '{default: 0};
    int m_since [N] = '{default: 0};
    bit m_lvl [N] = '{default: 1'b0};
    bit m_pp [N] = '{default: 1'b0};
    bit m_rp [N] = '{default: 1'b0};
    bit m_lp [N] = '{default: 1'b0};
    bit m_tg [N] = '{default: 1'b0};

    always @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_p1[i] = 0; m_p2[i] = 0; m_run[i] = 0; m_since[i] = 0;
                m_lvl[i] = 0; m_pp[i] = 0; m_rp[i] = 0; m_lp[i] = 0; m_tg[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                bit seen, was_high, was_press;
                seen      = m_p2[i];
                m_p2[i]   = m_p1[i];
                m_p1[i]   = ~key_in[i];
                was_high  = m_lvl[i];
                was_press = m_pp[i];
                m_pp[i] = 0;
                m_rp[i] = 0;
                if (seen != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_lvl[i] = seen;
                        m_run[i] = 0;
                        if (seen) m_pp[i] = 1; else m_rp[i] = 1;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_since[i] = was_high ? m_since[i] + 1 : 0;
                m_lp[i] = was_high && (m_since[i] == LNG);
                if (was_press) m_tg[i] = ~m_tg[i];
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] e_l, e_p, e_r, e_g, e_t;
        for (int i = 0; i < N; i++) begin
            e_l[i] = m_lvl[i]; e_p[i] = m_pp[i]; e_r[i] = m_rp[i];
            e_g[i] = m_lp[i];  e_t[i] = m_tg[i];
        end
        chk("model key_level", 32'(key_level), 32'(e_l));
        chk("model press_pulse", 32'(press_pulse), 32'(e_p));
        chk("model release_pulse", 32'(release_pulse), 32'(e_r));
        chk("model long_pulse", 32'(long_pulse), 32'(e_g));
        chk("model toggle", 32'(toggle), 32'(e_t));
        if (press_pulse[0]) press_cnt0++;
        if (long_pulse[1]) long_cnt1++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic reset_pulse();
        sys_rst_n = 1'b0;
        step(2);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        step(3);
        chk("reset outputs", 32'({key_level, press_pulse, release_pulse, long_pulse, toggle}), 32'd0);
        sys_rst_n = 1'b1;
        step(3);

        // Clean press on key 0
        key_in[0] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            chk("clean lvl0", 32'(key_level[0]), 32'(k >= 10));
            chk("clean press0", 32'(press_pulse[0]), 32'(k == 10));
            chk("clean tog0", 32'(toggle[0]), 32'(k >= 11));
            chk("clean ch1 static", 32'({key_level[1], press_pulse[1], toggle[1]}), 32'd0);
        end
        key_in[0] = 1'b1;
        step(14);
        chk("clean lvl0 released", 32'(key_level[0]), 32'd0);

        // Bounce on key 0
        key_in[0] = 1'b0; step(5);
        key_in[0] = 1'b1; step(2);
        key_in[0] = 1'b0; step(5);
        key_in[0] = 1'b1; step(14);
        chk("bounce press count", 32'(press_cnt0), 32'd1);
        chk("bounce tog0", 32'(toggle[0]), 32'd1);

        // Long press on key 1
        key_in[1] = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            step(1);
            chk("long lvl1", 32'(key_level[1]), 32'(k >= 10));
            chk("long pulse1", 32'(long_pulse[1]), 32'(k == 42));
        end
        key_in[1] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            chk("long release1", 32'(release_pulse[1]), 32'(k == 10));
        end
        chk("long count once", 32'(long_cnt1), 32'd1);

        // Short press then full-length press on key 1
        key_in[1] = 1'b0; step(20);
        key_in[1] = 1'b1; step(14);
        chk("short no long", 32'(long_cnt1), 32'd1);
        key_in[1] = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            step(1);
            chk("restart long1", 32'(long_pulse[1]), 32'(k == 42));
        end
        key_in[1] = 1'b1; step(14);
        chk("restart long count", 32'(long_cnt1), 32'd2);

        // Both keys together from a fresh reset
        reset_pulse();
        step(2);
        for (int rep = 1; rep <= 2; rep++) begin
            key_in = 2'b00;
            for (int k = 1; k <= 12; k++) begin
                step(1);
                chk("both press", 32'(press_pulse), (k == 10) ? 32'd3 : 32'd0);
            end
            key_in = 2'b11;
            for (int k = 1; k <= 14; k++) begin
                step(1);
                chk("both release", 32'(release_pulse), (k == 10) ? 32'd3 : 32'd0);
            end
            chk("both toggle", 32'(toggle), (rep == 1) ? 32'd3 : 32'd0);
        end

        // Reset in the middle of key 0 debounce
        key_in[0] = 1'b0;
        step(4);
        sys_rst_n = 1'b0;
        #1;
        chk("async reset outputs", 32'({key_level, press_pulse, release_pulse, long_pulse, toggle}), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            step(1);
            chk("held reset outputs", 32'({key_level, press_pulse, toggle}), 32'd0);
        end
        sys_rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            chk("post-reset press0", 32'(press_pulse[0]), 32'(k == 10));
            chk("post-reset lvl0", 32'(key_level[0]), 32'(k >= 10));
        end
        key_in[0] = 1'b1;
        step(14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/key_debounce_multi.md
# key_debounce_multi

Parametrised multi-channel push-button conditioner, the successor to the single-key debouncer used for the debug button. Each of N_KEYS asynchronous key inputs is synchronised and debounced with a cycle-count timer. Each channel then provides a clean level, one-cycle press/release pulses, a one-shot long-press pulse and a press-toggled latch. It sits between board pins and control logic such as debug/step mode, LEDs and mode select, replacing ad-hoc per-button instances.

## Interface
- N_KEYS, 4: number of independent channels (1..32).
- DB_CYCLES, 1_000_000: stable-input cycles required to accept a change (20 ms at 50 MHz); must be ≥ 2.
- LONG_CYCLES, 50_000_000: cycles key_level must stay pressed before long_pulse (1 s at 50 MHz); must be ≥ 2.
- ACTIVE_LOW, 1: 1 = pressed key drives pin low; 0 = pressed drives high.
- TOGGLE_INIT, 0: reset value of every toggle bit.

Ports:
- clk  in  1  system clock.
- sys_rst_n  in  1  reset, asynchronous, active-low; clock clk.
- key_in  in  N_KEYS  raw asynchronous button pins.
- key_level  out  N_KEYS  debounced state, 1 = pressed (polarity-normalised).
- press_pulse  out  N_KEYS  one-cycle pulse on accepted press.
- release_pulse  out  N_KEYS  one-cycle pulse on accepted release.
- long_pulse  out  N_KEYS  one-cycle pulse once per press held ≥ LONG_CYCLES.
- toggle  out  N_KEYS  flips on every press_pulse.

## Operation
- Channels are fully independent. There is no shared state between channels.
- Synchroniser: 2-flop chain per bit, reset to the idle pin level (ACTIVE_LOW ? 1 : 0). raw_p = sync2 XOR ACTIVE_LOW, so 1 = pressed.
- Debounce counter db_cnt, width $clog2(DB_CYCLES), reset 0. On each edge:
  - If raw_p == key_level: db_cnt <= 0. Any glitch restarts the count.
  - Else, if db_cnt == DB_CYCLES-1: key_level <= raw_p and db_cnt <= 0.
  - Else: db_cnt <= db_cnt+1.
- press_pulse and release_pulse are registered. They are high for exactly the cycle in which key_level first shows its new value, 1 and 0 respectively.
- Hold counter hold_cnt, width $clog2(LONG_CYCLES+1), reset 0:
  - key_level == 0: hold_cnt cleared.
  - key_level == 1 and hold_cnt < LONG_CYCLES: hold_cnt increments.
  - hold_cnt saturates at LONG_CYCLES.
- long_pulse <= key_level && (hold_cnt == LONG_CYCLES-1). Saturation guarantees one pulse per press, with no auto-repeat.
- toggle[i] <= ~toggle[i] on press_pulse[i]; it is unaffected by release and long press.
- Reset values: key_level 0, all pulses 0, toggle = {N_KEYS{TOGGLE_INIT}}, counters 0, synchronisers at idle level.
- A key held pressed through reset deassertion is accepted as a press after DB_CYCLES+2 edges, producing press_pulse and toggle.

## Timing
- Count the first edge that samples a changed key_in as edge 1. key_level updates on edge DB_CYCLES+2. press_pulse or release_pulse is high in the cycle following that edge, aligned with the new key_level.
- An input bounce shorter than DB_CYCLES consecutive cycles, measured after synchronisation, produces no output change.
- long_pulse is high in the cycle after edge E+LONG_CYCLES, where E is the edge on which key_level rose. If release is accepted on that same edge, long_pulse and release_pulse are both asserted in the same cycle.
- Release accepted before E+LONG_CYCLES: no long_pulse, and hold_cnt restarts from 0 on the next press.
- Asynchronous reset mid-count or mid-hold: all state returns to reset values immediately. No pulse is emitted on reset deassertion unless a press is re-accepted.

## Test plan
Use N_KEYS=2, DB_CYCLES=8, LONG_CYCLES=32, ACTIVE_LOW=1 for all scenarios.

- Clean press on key 0 (key_in[0] 1→0 held): key_level[0] rises on edge 10; press_pulse[0] lasts 1 cycle; toggle[0] goes 0→1; channel 1 outputs stay static.
- Bounce on key 0: key_in[0] low 5 cycles, high 2, low 5, then high. Required: no key_level, press, or toggle activity.
- Long press on key 1 held 60 cycles: long_pulse[1] occurs exactly once, 32 cycles after key_level[1] rises. release_pulse[1] follows 10 edges after the pin returns high.
- Short press on key 1 (key_level high for 20 cycles): no long_pulse. A second press produces long_pulse at the full 32-cycle count, confirming the counter restarts.
- Both keys pressed on the same cycle: identical, simultaneous pulses on both channels. After a second press on each key, toggle = 2'b00.
- Reset asserted 4 cycles into the debounce of key 0: all outputs return to reset values with key_level = 0 and no pulses. If the pin is still low after reset release, press_pulse fires 10 edges after release.
